mcu_assembler: RTL and testbench
================================

// Module: mcu_assembler
// PURPOSE
//  Sits directly downstream of supersample_top in the 4:2:0 decode path.
//  Collects one MCU (4 Y blocks, 4 upsampled Cb blocks, 4 upsampled Cr blocks)
//  into 16x16 per-channel pixel buffers, level-shifts (+128) and clamps each sample to 8 bits.
//  Then streams the MCU out as 256 raster-order YCbCr pixels under a valid/ready handshake.
// PARAMETERS
//  CH     `CH(3)  number of colour channels; sets ch_in width $clog2(CH+1)
//  IN_W   9       signed input sample width
//  PIX_W  8       unsigned output sample width
// PORTS
//  clk          in   1            clock
//  rst          in   1            reset, asynchronous, active-high
//  valid_in     in   4            per-block valid; bit k qualifies block_(k+1)_in
//  ch_in        in   $clog2(CH+1) 0=Y, 1=Cb, 2=Cr
//  block_1_in   in   IN_W [7:0][7:0] signed; TL quadrant (Y: the single block)
//  block_2_in   in   IN_W [7:0][7:0] signed; TR quadrant
//  block_3_in   in   IN_W [7:0][7:0] signed; BL quadrant
//  block_4_in   in   IN_W [7:0][7:0] signed; BR quadrant
//  in_ready     out  1            block accepted when valid_in!=0 && in_ready
//  pix_valid    out  1            output pixel valid
//  pix_ready    in   1            downstream (colour converter) accepts pixel
//  pix_y/cb/cr  out  PIX_W each   unsigned samples, clamp(x+128,0,255)
//  pix_row      out  4            pixel row within MCU, 0..15
//  pix_col      out  4            pixel column within MCU, 0..15
//  mcu_last     out  1            high with pixel (15,15)
//  seq_err      out  1            sticky protocol-error flag
// BEHAVIOUR
//  - Reset: state=ACC_Y, ycnt=0, pix_valid=0, pix_y/cb/cr=0, pix_row/col=0, mcu_last=0, seq_err=0.
//    in_ready = (state!=DRAIN), so it is 1 during and after reset. Buffer contents are don't-care.
//  - Reset mid-operation discards the partial or draining MCU. No pixel completes after rst rises.
//  - FSM:
//    ACC_Y  : accepts ch_in=0 with valid_in=4'b0001.
//             Store block_1_in into Y quadrant ycnt (0=TL,1=TR,2=BL,3=BR).
//             ycnt++. On ycnt==3 go to ACC_CB.
//    ACC_CB : accepts ch_in=1 with valid_in=4'b1111.
//             Store all 4 quadrants into the Cb buffer. Go to ACC_CR.
//    ACC_CR : accepts ch_in=2 with valid_in=4'b1111.
//             Store into the Cr buffer. Go to DRAIN.
//    DRAIN  : in_ready=0. Pixel index p=0..255 in raster order (row=p[7:4], col=p[3:0]).
//  - Protocol errors. Any of the following sets seq_err=1 (sticky until rst):
//    a wrong ch_in for the state; a wrong valid_in mask; ch_in==3.
//    The offending block is dropped and state is unchanged.
//  - valid_in!=0 while in_ready=0 (DRAIN): the block is dropped, seq_err=1, output stream unaffected.
//  - Write: a block is written to the buffer on the accepting edge, 64 samples in parallel per quadrant.
//    Level shift: 10-bit signed sum s = sign_ext(x) + 128. Output = (s<0)?0 : (s>255)?255 : s[7:0].
//  - Latency:
//    pix_valid=1 with pixel (0,0) on the cycle after the Cr-accepting edge.
//    Output regs load the next pixel on each pix_valid && pix_ready edge, giving 1 pixel/cycle when
//    pix_ready is held high. The MCU drains in 256 cycles minimum.
//  - Stall: while pix_valid && !pix_ready, pix_* / pix_row / pix_col / mcu_last hold stable.
//  - End of MCU: on acceptance of p=255 (mcu_last=1) the block does the following:
//    pix_valid drops the next cycle; state goes to ACC_Y with ycnt=0; in_ready=1 the same next cycle.
//    The next MCU cannot overlap the drain (single-buffered).
//  - pix_valid never deasserts without a handshake once asserted.
// STRUCTURE
//  - jpeg_pkg holds:
//    mcu_state_e {ACC_Y, ACC_CB, ACC_CR, DRAIN}; constants CH_Y=0, CH_CB=1, CH_CR=2;
//    LVL_SHIFT=128; MCU_DIM=16; function clamp_u8(signed [IN_W-1:0]).
//  - Sub-module mcu_plane_buf (instantiated 3x). It is a 16x16 x PIX_W register array with:
//    a quadrant write port (quad select, 8x8 block, applies clamp_u8) and a
//    combinational read at (row,col).
//  - The FSM, counters, handshake and output registers live in mcu_assembler.
// TESTING
//  1 Ramp MCU: Y quadrant q, sample (i,j) = q*16+i*8+j-128, Cb=-128+i, Cr=127-j, pix_ready=1.
//    Expect 256 pixels in raster order, first pix_valid 1 cycle after the Cr block.
//    Expect pix_y(0,8)=16+0 (TR), pix_cb(r,c)=(r%8), pix_cr(r,c)=255-(c%8), mcu_last only at (15,15).
//  2 Clamp: Y samples -256 and 255.
//    Expect pix_y=0 and 255 respectively; a sample of -128 gives 0, a sample of 0 gives 128.
//  3 Backpressure: toggle pix_ready pseudo-randomly.
//    Expect no pixel lost or duplicated, outputs stable during stalls, and the sequence matching
//    scenario 1.
//  4 Sequence errors:
//    Cb block sent during ACC_Y -> seq_err=1, ycnt unchanged.
//    Y with valid_in=4'b1111 -> dropped.
//    Block sent during DRAIN -> dropped, output stream intact.
//  5 Back-to-back MCUs: 2nd MCU offered as soon as in_ready rises.
//    Expect in_ready=1 exactly one cycle after the p=255 handshake; 2nd MCU data correct.
//  6 rst asserted mid-DRAIN at p=100 (async).
//    Expect pix_valid=0, in_ready=1, and seq_err=0 immediately. A fresh MCU then drains from p=0.

Source files
------------

// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared types, constants and sample clamp for the MCU assembler
// Contents:
//   mcu_state_e   accumulation / drain states of the MCU assembler
//   CH_Y/CB/CR    channel codes carried on ch_in
//   SAMPLE_W      signed input sample width, OUT_W unsigned output width
//   LVL_SHIFT     level shift added before clamping, MCU_DIM pixels per MCU side
//   clamp_u8      level shift plus saturation to the unsigned output range
package jpeg_pkg;

  localparam int SAMPLE_W  = 9;
  localparam int OUT_W     = 8;
  localparam int LVL_SHIFT = 128;
  localparam int MCU_DIM   = 16;

  localparam int CH_Y  = 0;
  localparam int CH_CB = 1;
  localparam int CH_CR = 2;

  typedef enum logic [1:0] {
    ACC_Y  = 2'd0,
    ACC_CB = 2'd1,
    ACC_CR = 2'd2,
    DRAIN  = 2'd3
  } mcu_state_e;

  // One extra bit of headroom holds x+128 for every SAMPLE_W-bit input, so
  // the top bit of s is the sign and any bit above OUT_W means overflow.
  function automatic logic [OUT_W-1:0] clamp_u8(input logic signed [SAMPLE_W-1:0] x);
    logic [SAMPLE_W:0] s;
    s = {x[SAMPLE_W-1], x} + (SAMPLE_W+1)'(LVL_SHIFT);
    if (s[SAMPLE_W]) begin
      clamp_u8 = '0;
    end else if (|s[SAMPLE_W-1:OUT_W]) begin
      clamp_u8 = '1;
    end else begin
      clamp_u8 = s[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mcu_plane_buf.sv
// rtl/mcu_plane_buf.sv - 16x16 single-channel pixel buffer with quadrant writes
// Ports:
//   clk     clock (buffer contents need no reset)
//   we_i    per-quadrant write enable, bit q = quadrant q (0=TL,1=TR,2=BL,3=BR)
//   blk_i   four 8x8 signed blocks, blk_i[q] feeds quadrant q
//   row_i   read row 0..15
//   col_i   read column 0..15
//   rd_o    clamped, level-shifted sample at (row_i, col_i), combinational
module mcu_plane_buf
  import jpeg_pkg::*;
(
  input  logic                               clk,
  input  logic [3:0]                         we_i,
  input  logic [3:0][7:0][7:0][SAMPLE_W-1:0] blk_i,
  input  logic [3:0]                         row_i,
  input  logic [3:0]                         col_i,
  output logic [OUT_W-1:0]                   rd_o
);

  logic [OUT_W-1:0] cells [MCU_DIM][MCU_DIM];

  // Each cell belongs to exactly one quadrant, so every cell has a single
  // write source selected at elaboration time.
  for (genvar r = 0; r < MCU_DIM; r++) begin : g_row
    for (genvar c = 0; c < MCU_DIM; c++) begin : g_col
      localparam int Q = (r / 8) * 2 + (c / 8);
      logic [OUT_W-1:0] cell_q;

      always_ff @(posedge clk) begin
        if (we_i[Q]) begin
          cell_q <= clamp_u8(blk_i[Q][r % 8][c % 8]);
        end
      end

      assign cells[r][c] = cell_q;
    end
  end

  assign rd_o = cells[row_i][col_i];

endmodule

// File: rtl/mcu_assembler.sv
// rtl/mcu_assembler.sv - gathers one 4:2:0 MCU and streams it as 256 raster YCbCr pixels
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   valid_in[3:0]     per-block valid, bit k qualifies block_(k+1)_in
//   ch_in             0=Y, 1=Cb, 2=Cr
//   block_1..4_in     8x8 signed blocks (TL, TR, BL, BR); Y uses block_1_in only
//   in_ready          high whenever the MCU is not draining
//   pix_valid/ready   output pixel handshake
//   pix_y/cb/cr       clamp(x+128) samples of the presented pixel
//   pix_row/col       position of the presented pixel within the MCU
//   mcu_last          presented pixel is (15,15)
//   seq_err           sticky protocol-error flag
module mcu_assembler
  import jpeg_pkg::*;
#(
  parameter  int CH    = 3,
  parameter  int IN_W  = SAMPLE_W,
  parameter  int PIX_W = OUT_W,
  localparam int CHW   = $clog2(CH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   valid_in,
  input  logic [CHW-1:0]               ch_in,
  input  logic [7:0][7:0][IN_W-1:0]    block_1_in,
  input  logic [7:0][7:0][IN_W-1:0]    block_2_in,
  input  logic [7:0][7:0][IN_W-1:0]    block_3_in,
  input  logic [7:0][7:0][IN_W-1:0]    block_4_in,
  output logic                         in_ready,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [PIX_W-1:0]             pix_y,
  output logic [PIX_W-1:0]             pix_cb,
  output logic [PIX_W-1:0]             pix_cr,
  output logic [3:0]                   pix_row,
  output logic [3:0]                   pix_col,
  output logic                         mcu_last,
  output logic                         seq_err
);

  mcu_state_e state_q, state_d;
  logic [1:0] ycnt_q, ycnt_d;
  logic [7:0] p_q, p_d;
  logic       pix_valid_q, pix_valid_d;
  logic       seq_err_q, seq_err_d;

  logic       acc_y, acc_cb, acc_cr;
  logic       pix_hs;
  logic [3:0] y_we;

  logic [PIX_W-1:0] y_rd, cb_rd, cr_rd;

  assign in_ready = (state_q != DRAIN);
  assign pix_hs   = pix_valid_q && pix_ready;

  always_comb begin
    state_d     = state_q;
    ycnt_d      = ycnt_q;
    p_d         = p_q;
    pix_valid_d = pix_valid_q;
    seq_err_d   = seq_err_q;
    acc_y       = 1'b0;
    acc_cb      = 1'b0;
    acc_cr      = 1'b0;

    // A block that does not match what the current state expects is
    // dropped and only flagged; the FSM never moves on a bad block.
    if (valid_in != 4'b0000) begin
      unique case (state_q)
        ACC_Y: begin
          if (ch_in == CHW'(CH_Y) && valid_in == 4'b0001) acc_y = 1'b1;
          else seq_err_d = 1'b1;
        end
        ACC_CB: begin
          if (ch_in == CHW'(CH_CB) && valid_in == 4'b1111) acc_cb = 1'b1;
          else seq_err_d = 1'b1;
        end
        ACC_CR: begin
          if (ch_in == CHW'(CH_CR) && valid_in == 4'b1111) acc_cr = 1'b1;
          else seq_err_d = 1'b1;
        end
        default: seq_err_d = 1'b1;
      endcase
    end

    if (acc_y) begin
      ycnt_d = ycnt_q + 2'd1;
      if (ycnt_q == 2'd3) state_d = ACC_CB;
    end
    if (acc_cb) state_d = ACC_CR;
    // The Cr edge writes the last buffer and starts presenting pixel 0 at
    // once; reads are combinational so the fresh data is visible next cycle.
    if (acc_cr) begin
      state_d     = DRAIN;
      pix_valid_d = 1'b1;
      p_d         = 8'd0;
    end

    if (state_q == DRAIN && pix_hs) begin
      if (p_q == 8'hFF) begin
        pix_valid_d = 1'b0;
        state_d     = ACC_Y;
        ycnt_d      = 2'd0;
        p_d         = 8'd0;
      end else begin
        p_d = p_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC_Y;
      ycnt_q      <= 2'd0;
      p_q         <= 8'd0;
      pix_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ycnt_q      <= ycnt_d;
      p_q         <= p_d;
      pix_valid_q <= pix_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign y_we = acc_y ? (4'b0001 << ycnt_q) : 4'b0000;

  mcu_plane_buf u_y_buf (
    .clk   (clk),
    .we_i  (y_we),
    .blk_i ({4{block_1_in}}),
    .row_i (p_q[7:4]),
    .col_i (p_q[3:0]),
    .rd_o  (y_rd)
  );

  mcu_plane_buf u_cb_buf (
    .clk   (clk),
    .we_i  ({4{acc_cb}}),
    .blk_i ({block_4_in, block_3_in, block_2_in, block_1_in}),
    .row_i (p_q[7:4]),
    .col_i (p_q[3:0]),
    .rd_o  (cb_rd)
  );

  mcu_plane_buf u_cr_buf (
    .clk   (clk),
    .we_i  ({4{acc_cr}}),
    .blk_i ({block_4_in, block_3_in, block_2_in, block_1_in}),
    .row_i (p_q[7:4]),
    .col_i (p_q[3:0]),
    .rd_o  (cr_rd)
  );

  // Buffers are unreset, so samples are forced to zero whenever no pixel
  // is being presented. The index only moves on a handshake, which keeps
  // all pixel outputs stable through a stall.
  assign pix_valid = pix_valid_q;
  assign pix_y     = pix_valid_q ? y_rd  : '0;
  assign pix_cb    = pix_valid_q ? cb_rd : '0;
  assign pix_cr    = pix_valid_q ? cr_rd : '0;
  assign pix_row   = p_q[7:4];
  assign pix_col   = p_q[3:0];
  assign mcu_last  = pix_valid_q && (p_q == 8'hFF);
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_mcu_assembler.sv
// tb/tb_mcu_assembler.sv - self-checking bench for mcu_assembler
module tb_mcu_assembler;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0]             valid_in;
  logic [1:0]             ch_in;
  logic [7:0][7:0][8:0]   b1, b2, b3, b4;
  logic                   in_ready, pix_valid, pix_ready;
  logic [7:0]             pix_y, pix_cb, pix_cr;
  logic [3:0]             pix_row, pix_col;
  logic                   mcu_last, seq_err;

  always #5 clk = ~clk;

  mcu_assembler dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ch_in      (ch_in),
    .block_1_in (b1),
    .block_2_in (b2),
    .block_3_in (b3),
    .block_4_in (b4),
    .in_ready   (in_ready),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_y      (pix_y),
    .pix_cb     (pix_cb),
    .pix_cr     (pix_cr),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .mcu_last   (mcu_last),
    .seq_err    (seq_err)
  );

  int checks = 0;
  int errors = 0;

  int ysent  [16][16];
  int cbsent [16][16];
  int crsent [16][16];
  int cap_y  [256];

  typedef struct {
    int sample;
    int exp;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int clamp_m(input int v);
    int s;
    s = v + 128;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  // mode 0: ramp q*16+i*8+j-128; mode 1: ramp with clamp table in TL corner
  task automatic fill_y(input int q, input int mode);
    int v;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        v = q * 16 + i * 8 + j - 128;
        if (mode == 1 && q == 0 && (i * 8 + j) < 10) v = tbl[i * 8 + j].sample;
        b1[i][j] = 9'(v);
        ysent[(q / 2) * 8 + i][(q % 2) * 8 + j] = v;
      end
    end
  endtask

  // mode 0: Cb=-128+i, Cr=127-j; mode 1: alternate patterns per quadrant
  task automatic fill_c(input int ch, input int mode);
    int v;
    logic [8:0] t;
    for (int q = 0; q < 4; q++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          if (ch == 1) v = (mode == 0) ? (-128 + i) : ((i * 8 + j) * 4 - 128 + q);
          else         v = (mode == 0) ? (127 - j)  : (100 - q * 60 + i - j);
          t = 9'(v);
          case (q)
            0: b1[i][j] = t;
            1: b2[i][j] = t;
            2: b3[i][j] = t;
            default: b4[i][j] = t;
          endcase
          if (ch == 1) cbsent[(q / 2) * 8 + i][(q % 2) * 8 + j] = v;
          else         crsent[(q / 2) * 8 + i][(q % 2) * 8 + j] = v;
        end
      end
    end
  endtask

  // Called and returns at a falling edge.
  task automatic send(input logic [1:0] ch, input logic [3:0] vm);
    ch_in    = ch;
    valid_in = vm;
    @(posedge clk);
    #1;
    valid_in = 4'b0000;
    @(negedge clk);
  endtask

  task automatic load_mcu(input int ymode, input int cmode);
    for (int q = 0; q < 4; q++) begin
      fill_y(q, ymode);
      send(2'd0, 4'b0001);
    end
    fill_c(1, cmode);
    send(2'd1, 4'b1111);
    fill_c(2, cmode);
    chk("pre_cr_valid", pix_valid, 1'b0);
    send(2'd2, 4'b1111);
    chk("cr_latency", pix_valid, 1'b1);
  endtask

  // mode 1 = random backpressure; inj_at/rst_at = pixel index, -1 = off
  task automatic drain(input int mode, input int inj_at, input int rst_at);
    int idx, cyc, rr, cc;
    bit injected;
    logic r;
    logic [34:0] got, exp;
    idx = 0;
    cyc = 0;
    injected = 0;
    while (idx < 256 && cyc < 3000) begin
      if (idx == rst_at) begin
        #2 rst = 1'b1;
        #1 chk("rst_mid_drain", {pix_valid, in_ready, seq_err}, 3'b010);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", {pix_valid, in_ready}, 2'b01);
        return;
      end
      rr  = idx / 16;
      cc  = idx % 16;
      got = {pix_valid, in_ready, pix_row, pix_col, pix_y, pix_cb, pix_cr, mcu_last};
      exp = {1'b1, 1'b0, 4'(rr), 4'(cc), 8'(clamp_m(ysent[rr][cc])),
             8'(clamp_m(cbsent[rr][cc])), 8'(clamp_m(crsent[rr][cc])), (idx == 255)};
      chk($sformatf("pix%0d", idx), got, exp);
      valid_in = 4'b0000;
      if (idx == inj_at && !injected) begin
        ch_in    = 2'd0;
        valid_in = 4'b0001;
        injected = 1;
      end
      r = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_ready = r;
      if (r) begin
        cap_y[idx] = int'(pix_y);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    valid_in = 4'b0000;
    if (idx < 256) chk("drain_timeout", idx, 256);
    chk("post_drain", {pix_valid, in_ready}, 2'b01);
  endtask

  initial begin
    tbl[0] = '{-256, 0};
    tbl[1] = '{255, 255};
    tbl[2] = '{-128, 0};
    tbl[3] = '{0, 128};
    tbl[4] = '{-129, 0};
    tbl[5] = '{127, 255};
    tbl[6] = '{128, 255};
    tbl[7] = '{-1, 127};
    tbl[8] = '{1, 129};
    tbl[9] = '{-127, 1};

    rst       = 1'b1;
    valid_in  = 4'b0000;
    ch_in     = 2'd0;
    pix_ready = 1'b0;
    b1 = '0; b2 = '0; b3 = '0; b4 = '0;

    repeat (3) @(negedge clk);
    chk("reset_state",
        {in_ready, pix_valid, pix_y, pix_cb, pix_cr, pix_row, pix_col, mcu_last, seq_err},
        36'h800000000);
    rst = 1'b0;
    @(negedge clk);
    pix_ready = 1'b1;

    // Ramp MCU with continuous ready
    load_mcu(0, 0);
    drain(0, -1, -1);
    chk("y_0_0", cap_y[0], 0);
    chk("y_0_8_tr", cap_y[8], 16);
    chk("y_15_15", cap_y[255], 111);
    chk("seq_err_clean", seq_err, 1'b0);

    // Back-to-back MCU carrying the clamp table
    load_mcu(1, 1);
    drain(0, -1, -1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("clamp%0d", k), cap_y[(k / 8) * 16 + (k % 8)], tbl[k].exp);
    end

    // Random backpressure
    load_mcu(0, 0);
    drain(1, -1, -1);

    // Protocol errors
    fill_y(0, 0);
    send(2'd0, 4'b0001);
    fill_c(1, 0);
    send(2'd1, 4'b1111);
    chk("seq_err_cb_in_y", seq_err, 1'b1);
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) b1[i][j] = 9'd200;
    send(2'd0, 4'b1111);
    send(2'd3, 4'b0001);
    chk("in_ready_acc_y", in_ready, 1'b1);
    for (int q = 1; q < 4; q++) begin
      fill_y(q, 0);
      send(2'd0, 4'b0001);
    end
    fill_c(1, 0);
    send(2'd1, 4'b1111);
    fill_c(2, 0);
    chk("pre_cr_valid_err", pix_valid, 1'b0);
    send(2'd2, 4'b1111);
    chk("cr_latency_err", pix_valid, 1'b1);
    drain(0, 50, -1);
    chk("seq_err_sticky", seq_err, 1'b1);

    // Asynchronous reset mid-drain, then a fresh MCU
    load_mcu(1, 0);
    drain(0, -1, 100);
    repeat (2) @(negedge clk);
    chk("idle_after_rst", {pix_valid, in_ready, seq_err}, 3'b010);
    load_mcu(0, 1);
    drain(1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
